// File: rtl/bcd_counter_pkg.sv
// Shared types, constants and helpers for the cascadable BCD counter family.
package bcd_counter_pkg;

  typedef enum logic {RUN, APPLY} state_t;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX_DIGIT = 4'd9;

  typedef struct packed {
    bcd_t tens;
    bcd_t ones;
    logic wrap;
  } bcd_pair_t;

  // Next digit pair for a single step; wrap is set on a full-range rollover.
  function automatic bcd_pair_t bcd_next(input bcd_t tens, input bcd_t ones,
                                         input bcd_t tens_max, input logic down);
    bcd_pair_t r;
    r.tens = tens;
    r.ones = ones;
    r.wrap = 1'b0;
    if (!down) begin
      if (ones < BCD_MAX_DIGIT) begin
        r.ones = ones + 4'd1;
      end else begin
        r.ones = 4'd0;
        if (tens == tens_max) begin
          r.tens = 4'd0;
          r.wrap = 1'b1;
        end else begin
          r.tens = tens + 4'd1;
        end
      end
    end else begin
      if (ones != 4'd0) begin
        r.ones = ones - 4'd1;
      end else begin
        r.ones = BCD_MAX_DIGIT;
        if (tens == 4'd0) begin
          r.tens = tens_max;
          r.wrap = 1'b1;
        end else begin
          r.tens = tens - 4'd1;
        end
      end
    end
    return r;
  endfunction

  function automatic logic bcd_legal(input bcd_t tens, input bcd_t ones, input bcd_t tens_max);
    return (ones <= BCD_MAX_DIGIT) && (tens <= tens_max);
  endfunction

endpackage

// File: rtl/bcd_digit_step.sv
// Combinational single-digit up/down step with programmable maximum and wrap flag.
module bcd_digit_step
  import bcd_counter_pkg::*;
(
  input  logic [3:0] i_digit,
  input  logic [3:0] i_max,
  input  logic       i_en,
  input  logic       i_down,
  output logic [3:0] o_digit,
  output logic       o_wrap
);

  always_comb begin
    o_digit = i_digit;
    o_wrap  = 1'b0;
    if (i_en) begin
      if (i_down) begin
        if (i_digit == 4'd0) begin
          o_digit = i_max;
          o_wrap  = 1'b1;
        end else begin
          o_digit = i_digit - 4'd1;
        end
      end else begin
        if (i_digit >= i_max) begin
          o_digit = 4'd0;
          o_wrap  = 1'b1;
        end else begin
          o_digit = i_digit + 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/bcd_mod60_counter.sv
// Two-digit cascadable BCD counter (00..TENS_MAX9) with valid/ready preset port.
// Define BCD_COUNTER_DOWN_EN to add the dir input for down counting.
module bcd_mod60_counter
  import bcd_counter_pkg::*;
#(
  parameter int TENS_MAX = 5
) (
`ifdef BCD_COUNTER_DOWN_EN
  input  logic       dir,
`endif
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_in,
  input  logic       clr,
  input  logic       load_valid,
  output logic       load_ready,
  input  logic [3:0] load_tens,
  input  logic [3:0] load_ones,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       carry_out,
  output logic       load_err
);

  localparam bcd_t TENS_MAX_D = 4'(TENS_MAX);

  state_t     r_state;
  state_t     w_state_next;
  logic [3:0] r_tens;
  logic [3:0] r_ones;
  logic [3:0] r_hold_tens;
  logic [3:0] r_hold_ones;
  logic       r_carry;
  logic       r_err;
  logic       r_ready;

  logic       w_capture;
  logic       w_err_next;
  logic [3:0] w_base_tens;
  logic [3:0] w_base_ones;
  logic [3:0] w_step_tens;
  logic [3:0] w_step_ones;
  logic       w_ones_wrap;
  logic       w_tens_wrap;
  logic       w_down;

`ifdef BCD_COUNTER_DOWN_EN
  assign w_down = dir;
`else
  assign w_down = 1'b0;
`endif

  // In APPLY a legal held value replaces the count before the tick is applied.
  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    w_err_next   = 1'b0;
    w_base_tens  = r_tens;
    w_base_ones  = r_ones;
    case (r_state)
      RUN: begin
        if (load_valid) begin
          w_capture    = 1'b1;
          w_state_next = APPLY;
        end
      end
      APPLY: begin
        w_state_next = RUN;
        if (bcd_legal(r_hold_tens, r_hold_ones, TENS_MAX_D)) begin
          w_base_tens = r_hold_tens;
          w_base_ones = r_hold_ones;
        end else begin
          w_err_next = 1'b1;
        end
      end
      default: w_state_next = RUN;
    endcase
  end

  bcd_digit_step u_ones (
    .i_digit (w_base_ones),
    .i_max   (BCD_MAX_DIGIT),
    .i_en    (tick_in),
    .i_down  (w_down),
    .o_digit (w_step_ones),
    .o_wrap  (w_ones_wrap)
  );

  bcd_digit_step u_tens (
    .i_digit (w_base_tens),
    .i_max   (TENS_MAX_D),
    .i_en    (w_ones_wrap),
    .i_down  (w_down),
    .o_digit (w_step_tens),
    .o_wrap  (w_tens_wrap)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= RUN;
      r_tens      <= 4'd0;
      r_ones      <= 4'd0;
      r_hold_tens <= 4'd0;
      r_hold_ones <= 4'd0;
      r_carry     <= 1'b0;
      r_err       <= 1'b0;
      r_ready     <= 1'b1;
    end else if (clr) begin
      r_state     <= RUN;
      r_tens      <= 4'd0;
      r_ones      <= 4'd0;
      r_hold_tens <= 4'd0;
      r_hold_ones <= 4'd0;
      r_carry     <= 1'b0;
      r_err       <= 1'b0;
      r_ready     <= 1'b1;
    end else begin
      r_state <= w_state_next;
      r_ready <= (w_state_next == RUN);
      r_tens  <= w_step_tens;
      r_ones  <= w_step_ones;
      r_carry <= w_tens_wrap;
      r_err   <= w_err_next;
      if (w_capture) begin
        r_hold_tens <= load_tens;
        r_hold_ones <= load_ones;
      end
    end
  end

  assign tens       = r_tens;
  assign ones       = r_ones;
  assign carry_out  = r_carry;
  assign load_err   = r_err;
  assign load_ready = r_ready;

endmodule

// File: tb/tb_bcd_mod60_counter.sv
// Randomized self-checking bench for bcd_mod60_counter against an arithmetic reference model.
module tb_bcd_mod60_counter;

  localparam int TM = 5;
  localparam int M  = (TM + 1) * 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick_in = 1'b0;
  logic       clr = 1'b0;
  logic       load_valid = 1'b0;
  logic       load_ready;
  logic [3:0] load_tens = 4'd0;
  logic [3:0] load_ones = 4'd0;
  logic [3:0] tens;
  logic [3:0] ones;
  logic       carry_out;
  logic       load_err;
  logic       dir = 1'b0;

  int n_checks = 0;
  int n_pass = 0;

  // Reference model: count held as a plain integer 0..M-1
  int m_val = 0;
  bit m_pend = 0;
  int m_ht = 0;
  int m_ho = 0;
  bit m_carry = 0;
  bit m_err = 0;

  always #5 clk = ~clk;

  bcd_mod60_counter #(.TENS_MAX(TM)) dut (
`ifdef BCD_COUNTER_DOWN_EN
    .dir        (dir),
`endif
    .clk        (clk),
    .rst        (rst),
    .tick_in    (tick_in),
    .clr        (clr),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_tens  (load_tens),
    .load_ones  (load_ones),
    .tens       (tens),
    .ones       (ones),
    .carry_out  (carry_out),
    .load_err   (load_err)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic model_reset();
    m_val = 0; m_pend = 0; m_ht = 0; m_ho = 0; m_carry = 0; m_err = 0;
  endtask

  task automatic model_edge(input bit t, input bit c, input bit v, input int lt, input int lo);
    if (c) begin
      model_reset();
    end else begin
      m_carry = 0;
      m_err = 0;
      if (m_pend) begin
        m_pend = 0;
        if (m_ho <= 9 && m_ht <= TM) m_val = m_ht * 10 + m_ho;
        else m_err = 1;
      end else if (v) begin
        m_pend = 1; m_ht = lt; m_ho = lo;
      end
      if (t) begin
        if (dir) begin
          if (m_val == 0) m_carry = 1;
          m_val = (m_val + M - 1) % M;
        end else begin
          if (m_val == M - 1) m_carry = 1;
          m_val = (m_val + 1) % M;
        end
      end
    end
  endtask

  // One clock cycle: drive, check ready, clock, check all outputs; one line per transaction.
  task automatic cyc(input bit t, input bit c, input bit v, input int lt, input int lo);
    @(negedge clk);
    tick_in = t; clr = c; load_valid = v; load_tens = 4'(lt); load_ones = 4'(lo);
    #1;
    check("ready", int'(load_ready), int'(!m_pend));
    @(posedge clk);
    model_edge(t, c, v, lt, lo);
    #1;
    check("tens", int'(tens), m_val / 10);
    check("ones", int'(ones), m_val % 10);
    check("carry", int'(carry_out), int'(m_carry));
    check("err", int'(load_err), int'(m_err));
    $display("t=%0t tick=%0d clr=%0d lv=%0d ld=%0d/%0d dir=%0d -> %0d%0d c=%0d e=%0d rdy=%0d",
             $time, t, c, v, lt, lo, dir, tens, ones, carry_out, load_err, load_ready);
  endtask

  int pulses;
  int first_pulse;
  int gap;

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_tens", int'(tens), 0);
    check("rst_ones", int'(ones), 0);
    check("rst_carry", int'(carry_out), 0);
    check("rst_err", int'(load_err), 0);
    check("rst_ready", int'(load_ready), 1);

    // 59 ticks then the wrap tick
    for (int i = 0; i < 59; i++) cyc(1, 0, 0, 0, 0);
    check("at59_tens", int'(tens), 5);
    check("at59_ones", int'(ones), 9);
    cyc(1, 0, 0, 0, 0);
    check("wrap_carry", int'(carry_out), 1);
    cyc(0, 0, 0, 0, 0);
    check("carry_one_cycle", int'(carry_out), 0);

    // 120 continuous ticks from 00: two pulses 60 apart
    pulses = 0; first_pulse = -1; gap = 0;
    for (int i = 1; i <= 120; i++) begin
      cyc(1, 0, 0, 0, 0);
      if (carry_out) begin
        pulses++;
        if (first_pulse < 0) first_pulse = i;
        else gap = i - first_pulse;
      end
    end
    check("pulse_count", pulses, 2);
    check("pulse_gap", gap, 60);

    // Legal loads, illegal loads, tick during APPLY
    cyc(0, 0, 1, 4, 7);
    cyc(0, 0, 0, 4, 7);
    check("load47", int'(tens) * 10 + int'(ones), 47);
    cyc(0, 0, 1, 5, 9);
    cyc(1, 0, 0, 5, 9);
    cyc(0, 0, 1, 6, 3);
    cyc(0, 0, 0, 6, 3);
    cyc(0, 0, 1, 2, 10);
    cyc(1, 0, 0, 2, 10);
    // Back-to-back loads accepted at N and N+2
    cyc(0, 0, 1, 1, 2);
    cyc(0, 0, 1, 3, 4);
    cyc(0, 0, 1, 3, 4);
    cyc(0, 0, 0, 0, 0);
    // clr during APPLY with tick high drops the held load
    cyc(0, 0, 1, 3, 3);
    cyc(1, 1, 0, 3, 3);
    cyc(0, 0, 0, 0, 0);

    // Asynchronous reset between edges
    for (int i = 0; i < 7; i++) cyc(1, 0, 0, 0, 0);
    @(posedge clk);
    model_edge(0, 0, 0, 0, 0);
    tick_in = 1'b0;
    #3 rst = 1'b1;
    #1;
    check("arst_tens", int'(tens), 0);
    check("arst_ones", int'(ones), 0);
    check("arst_ready", int'(load_ready), 1);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

`ifdef BCD_COUNTER_DOWN_EN
    dir = 1'b1;
    cyc(1, 0, 0, 0, 0);
    check("down_wrap", int'(tens) * 10 + int'(ones), M - 1);
    cyc(0, 0, 1, 1, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 0);
    check("down_10_09", int'(tens) * 10 + int'(ones), 9);
    dir = 1'b0;
`endif

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      bit t, c, v;
      int lt, lo;
      t = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 59) == 0);
      v = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 9) < 7) begin
        lt = $urandom_range(0, TM);
        lo = $urandom_range(0, 9);
      end else begin
        lt = $urandom_range(0, 15);
        lo = $urandom_range(0, 15);
      end
`ifdef BCD_COUNTER_DOWN_EN
      dir = ($urandom_range(0, 1) == 1);
`endif
      cyc(t, c, v, lt, lo);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
